// File: rtl/dispatch_pair_issue.sv
// Dual-issue dispatch stage: in-order issue of up to two queued instructions,
// gated by a register scoreboard and pairing rules, into a one-deep output register.
module dispatch_pair_issue #(
    parameter int DATA_W = 200,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        q_valid,
    input  logic [DATA_W-1:0] q_data0,
    input  logic [DATA_W-1:0] q_data1,
    input  logic [4:0]        q_rj0,
    input  logic [4:0]        q_rj1,
    input  logic [4:0]        q_rk0,
    input  logic [4:0]        q_rk1,
    input  logic [4:0]        q_rd0,
    input  logic [4:0]        q_rd1,
    input  logic              q_we0,
    input  logic              q_we1,
    input  logic              q_mem0,
    input  logic              q_mem1,
    input  logic              q_br0,
    input  logic              q_br1,
    input  logic              q_ser0,
    input  logic              q_ser1,
    output logic [1:0]        consume,
    output logic [1:0]        out_valid,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    input  logic              out_ready,
    input  logic [1:0]        wb_en,
    input  logic [4:0]        wb_rd0,
    input  logic [4:0]        wb_rd1,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  dual_cnt
);

    logic [NREG-1:0]   r_busy;
    logic [1:0]        r_out_valid;
    logic [DATA_W-1:0] r_out_data0;
    logic [DATA_W-1:0] r_out_data1;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_dual_cnt;

    logic [NREG-1:0]   w_busy;
    logic [NREG-1:0]   w_busy_nxt;
    logic              w_can_adv;
    logic              w_hz0;
    logic              w_hz1;
    logic              w_dep;
    logic              w_issue0;
    logic              w_issue1;

    // r0 is forced non-busy on the read side as well as never being set
    assign w_busy    = {r_busy[NREG-1:1], 1'b0};
    assign w_can_adv = !(|r_out_valid) || out_ready;

    assign w_hz0 = w_busy[q_rj0] | w_busy[q_rk0] | (q_we0 & w_busy[q_rd0]);
    assign w_hz1 = w_busy[q_rj1] | w_busy[q_rk1] | (q_we1 & w_busy[q_rd1]);
    assign w_dep = q_we0 && (q_rd0 != 5'd0) &&
                   ((q_rj1 == q_rd0) || (q_rk1 == q_rd0) || (q_we1 && (q_rd1 == q_rd0)));

    assign w_issue0 = q_valid[0] & w_can_adv & !w_hz0 & !flush & !rst
                    & !(q_ser0 & (|r_out_valid));
    assign w_issue1 = w_issue0 & q_valid[1] & !w_hz1 & !q_br0 & !q_ser0 & !q_ser1
                    & !(q_mem0 & q_mem1) & !w_dep;

    assign consume = {w_issue1, w_issue0};

    // Writebacks clear first, then issues set, so a same-cycle set survives
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en[0] && (wb_rd0 != 5'd0)) w_busy_nxt[wb_rd0] = 1'b0;
        if (wb_en[1] && (wb_rd1 != 5'd0)) w_busy_nxt[wb_rd1] = 1'b0;
        if (w_issue0 && q_we0 && (q_rd0 != 5'd0)) w_busy_nxt[q_rd0] = 1'b1;
        if (w_issue1 && q_we1 && (q_rd1 != 5'd0)) w_busy_nxt[q_rd1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) r_busy <= '0;
        else              r_busy <= w_busy_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= '0;
            r_out_data0 <= '0;
            r_out_data1 <= '0;
        end else if (flush) begin
            r_out_valid <= '0;
        end else if (w_can_adv) begin
            r_out_valid <= consume;
            r_out_data0 <= q_data0;
            r_out_data1 <= q_data1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_dual_cnt  <= '0;
        end else if (!flush) begin
            if (q_valid[0] && (consume == 2'b00)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (consume == 2'b11)                 r_dual_cnt  <= r_dual_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_out_valid;
    assign out_data0 = r_out_data0;
    assign out_data1 = r_out_data1;
    assign stall_cnt = r_stall_cnt;
    assign dual_cnt  = r_dual_cnt;

endmodule

// File: tb/tb_dispatch_pair_issue.sv
// Self-checking bench for dispatch_pair_issue: pairing-rule vector table,
// directed multi-cycle sequences and randomized traffic against a reference model.
module tb_dispatch_pair_issue;

    localparam int DW = 200;

    logic          clk = 1'b0;
    logic          rst, flush, out_ready;
    logic [1:0]    q_valid, wb_en;
    logic [DW-1:0] q_data0, q_data1;
    logic [4:0]    q_rj0, q_rj1, q_rk0, q_rk1, q_rd0, q_rd1, wb_rd0, wb_rd1;
    logic          q_we0, q_we1, q_mem0, q_mem1, q_br0, q_br1, q_ser0, q_ser1;
    logic [1:0]    consume, out_valid;
    logic [DW-1:0] out_data0, out_data1;
    logic [31:0]   stall_cnt, dual_cnt;

    always #5 clk = ~clk;

    dispatch_pair_issue #(.DATA_W(DW), .NREG(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .q_valid(q_valid),
        .q_data0(q_data0), .q_data1(q_data1),
        .q_rj0(q_rj0), .q_rj1(q_rj1), .q_rk0(q_rk0), .q_rk1(q_rk1),
        .q_rd0(q_rd0), .q_rd1(q_rd1), .q_we0(q_we0), .q_we1(q_we1),
        .q_mem0(q_mem0), .q_mem1(q_mem1), .q_br0(q_br0), .q_br1(q_br1),
        .q_ser0(q_ser0), .q_ser1(q_ser1), .consume(consume),
        .out_valid(out_valid), .out_data0(out_data0), .out_data1(out_data1),
        .out_ready(out_ready), .wb_en(wb_en), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
        .stall_cnt(stall_cnt), .dual_cnt(dual_cnt)
    );

    int errs = 0;
    int checks = 0;

    // Reference state: set of registers with an in-flight producer, output slots, counters
    bit            m_inflight[int];
    logic [1:0]    m_ov;
    logic [DW-1:0] m_d0, m_d1;
    logic [31:0]   m_stall, m_dual;

    typedef struct {
        logic [1:0] qv;
        logic [4:0] rj0, rk0, rd0;
        logic       we0, mem0, br0, ser0;
        logic [4:0] rj1, rk1, rd1;
        logic       we1, mem1, br1, ser1;
        logic [1:0] exp_c;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit pend(input logic [4:0] r);
        return (r != 5'd0) && m_inflight.exists(int'(r));
    endfunction

    // Issue decision, evaluated rule by rule: any blocking reason stops the slot
    function automatic logic [1:0] model_consume();
        bit ok0, ok1;
        ok0 = q_valid[0];
        if (rst || flush)                           ok0 = 0;
        if (m_ov != 2'b00 && !out_ready)            ok0 = 0;
        if (pend(q_rj0) || pend(q_rk0))             ok0 = 0;
        if (q_we0 && pend(q_rd0))                   ok0 = 0;
        if (q_ser0 && m_ov != 2'b00)                ok0 = 0;
        ok1 = ok0 && q_valid[1];
        if (pend(q_rj1) || pend(q_rk1))             ok1 = 0;
        if (q_we1 && pend(q_rd1))                   ok1 = 0;
        if (q_br0 || q_ser0 || q_ser1)              ok1 = 0;
        if (q_mem0 && q_mem1)                       ok1 = 0;
        if (q_we0 && q_rd0 != 0 && (q_rj1 == q_rd0 || q_rk1 == q_rd0)) ok1 = 0;
        if (q_we0 && q_we1 && q_rd0 != 0 && q_rd1 == q_rd0)            ok1 = 0;
        return {ok1, ok0};
    endfunction

    task automatic model_update(input logic [1:0] c);
        if (rst) begin
            m_ov = 0; m_d0 = '0; m_d1 = '0; m_stall = 0; m_dual = 0;
            m_inflight.delete();
        end else if (flush) begin
            m_ov = 0;
            m_inflight.delete();
        end else begin
            if (m_ov == 2'b00 || out_ready) begin
                m_ov = c;
                if (c[0]) m_d0 = q_data0;
                if (c[1]) m_d1 = q_data1;
            end
            if (wb_en[0] && wb_rd0 != 0) m_inflight.delete(int'(wb_rd0));
            if (wb_en[1] && wb_rd1 != 0) m_inflight.delete(int'(wb_rd1));
            if (c[0] && q_we0 && q_rd0 != 0) m_inflight[int'(q_rd0)] = 1;
            if (c[1] && q_we1 && q_rd1 != 0) m_inflight[int'(q_rd1)] = 1;
            if (q_valid[0] && c == 2'b00) m_stall++;
            if (c == 2'b11) m_dual++;
        end
    endtask

    // One clock: check consume, advance, then check the registered state
    task automatic cycle(input string tag, input bit use_tbl, input logic [1:0] tbl_c);
        logic [1:0] exp;
        #1;
        exp = model_consume();
        chk({tag, "_consume"}, 64'(consume), 64'(exp));
        if (use_tbl) chk({tag, "_consume_vec"}, 64'(consume), 64'(tbl_c));
        @(posedge clk);
        model_update(exp);
        #1;
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(m_ov));
        if (m_ov[0]) chk_data({tag, "_data0"}, out_data0, m_d0);
        if (m_ov[1]) chk_data({tag, "_data1"}, out_data1, m_d1);
        chk({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, "_dual_cnt"}, 64'(dual_cnt), 64'(m_dual));
    endtask

    task automatic idle();
        rst = 0; flush = 0; out_ready = 1; q_valid = 0; wb_en = 0; wb_rd0 = 0; wb_rd1 = 0;
        q_rj0 = 0; q_rk0 = 0; q_rd0 = 0; q_we0 = 0; q_mem0 = 0; q_br0 = 0; q_ser0 = 0;
        q_rj1 = 0; q_rk1 = 0; q_rd1 = 0; q_we1 = 0; q_mem1 = 0; q_br1 = 0; q_ser1 = 0;
    endtask

    task automatic rand_data();
        logic [223:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        q_data0 = t[DW-1:0];
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        q_data1 = t[DW-1:0];
    endtask

    task automatic s0(input int rj, input int rk, input int rd, input bit we);
        q_rj0 = 5'(rj); q_rk0 = 5'(rk); q_rd0 = 5'(rd); q_we0 = we;
    endtask

    task automatic s1(input int rj, input int rk, input int rd, input bit we);
        q_rj1 = 5'(rj); q_rk1 = 5'(rk); q_rd1 = 5'(rd); q_we1 = we;
    endtask

    task automatic clear_state();
        idle();
        flush = 1;
        cycle("flush", 1, 2'b00);
        idle();
    endtask

    function automatic vec_t mk(input logic [1:0] qv,
                                input int rj0, input int rk0, input int rd0, input bit we0,
                                input bit mem0, input bit br0, input bit ser0,
                                input int rj1, input int rk1, input int rd1, input bit we1,
                                input bit mem1, input bit br1, input bit ser1,
                                input logic [1:0] exp_c);
        vec_t v;
        v.qv = qv; v.exp_c = exp_c;
        v.rj0 = 5'(rj0); v.rk0 = 5'(rk0); v.rd0 = 5'(rd0); v.we0 = we0;
        v.mem0 = mem0; v.br0 = br0; v.ser0 = ser0;
        v.rj1 = 5'(rj1); v.rk1 = 5'(rk1); v.rd1 = 5'(rd1); v.we1 = we1;
        v.mem1 = mem1; v.br1 = br1; v.ser1 = ser1;
        return v;
    endfunction

    initial begin
        logic [31:0] d_before, s_before;

        tbl[0]  = mk(2'b11, 1, 2, 4, 1, 0, 0, 0,  1, 3, 5, 1, 0, 0, 0, 2'b11);
        tbl[1]  = mk(2'b11, 1, 2, 6, 1, 0, 0, 0,  6, 3, 8, 1, 0, 0, 0, 2'b01);
        tbl[2]  = mk(2'b11, 1, 2, 6, 1, 0, 0, 0,  3, 6, 8, 1, 0, 0, 0, 2'b01);
        tbl[3]  = mk(2'b11, 1, 2, 6, 1, 0, 0, 0,  3, 4, 6, 1, 0, 0, 0, 2'b01);
        tbl[4]  = mk(2'b11, 1, 2, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 2'b11);
        tbl[5]  = mk(2'b11, 1, 2, 9, 1, 1, 0, 0,  1, 2, 10, 1, 1, 0, 0, 2'b01);
        tbl[6]  = mk(2'b11, 1, 2, 9, 1, 1, 0, 0,  1, 2, 10, 1, 0, 0, 0, 2'b11);
        tbl[7]  = mk(2'b11, 1, 2, 9, 0, 0, 1, 0,  1, 2, 10, 1, 0, 0, 0, 2'b01);
        tbl[8]  = mk(2'b11, 1, 2, 9, 1, 0, 0, 0,  1, 2, 10, 0, 0, 1, 0, 2'b11);
        tbl[9]  = mk(2'b11, 1, 2, 9, 0, 0, 0, 1,  1, 2, 10, 1, 0, 0, 0, 2'b01);
        tbl[10] = mk(2'b11, 1, 2, 9, 1, 0, 0, 0,  1, 2, 10, 0, 0, 0, 1, 2'b01);
        tbl[11] = mk(2'b01, 1, 2, 9, 1, 0, 0, 0,  1, 2, 10, 1, 0, 0, 0, 2'b01);
        tbl[12] = mk(2'b00, 1, 2, 9, 1, 0, 0, 0,  1, 2, 10, 1, 0, 0, 0, 2'b00);
        tbl[13] = mk(2'b11, 1, 2, 6, 0, 0, 0, 0,  6, 6, 8, 1, 0, 0, 0, 2'b11);

        idle();
        q_data0 = '0; q_data1 = '0;
        m_ov = 0; m_d0 = '0; m_d1 = '0; m_stall = 0; m_dual = 0;
        rst = 1; q_valid = 2'b11;
        cycle("reset", 1, 2'b00);
        cycle("reset", 1, 2'b00);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk_data("reset_data0", out_data0, '0);
        chk_data("reset_data1", out_data1, '0);
        chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("reset_dual_cnt", 64'(dual_cnt), 64'd0);
        idle();

        foreach (tbl[i]) begin
            q_valid = tbl[i].qv;
            s0(tbl[i].rj0, tbl[i].rk0, tbl[i].rd0, tbl[i].we0);
            q_mem0 = tbl[i].mem0; q_br0 = tbl[i].br0; q_ser0 = tbl[i].ser0;
            s1(tbl[i].rj1, tbl[i].rk1, tbl[i].rd1, tbl[i].we1);
            q_mem1 = tbl[i].mem1; q_br1 = tbl[i].br1; q_ser1 = tbl[i].ser1;
            rand_data();
            cycle($sformatf("vec%0d", i), 1, tbl[i].exp_c);
            clear_state();
        end

        // T1: independent pair, then a reader of r4 must wait
        d_before = dual_cnt;
        q_valid = 2'b11; s0(1, 2, 4, 1); s1(1, 2, 5, 1); rand_data();
        cycle("T1", 1, 2'b11);
        chk("T1_ov", 64'(out_valid), 64'h3);
        chk("T1_dual_inc", 64'(dual_cnt), 64'(d_before + 1));
        idle(); q_valid = 2'b01; s0(4, 0, 9, 1);
        cycle("T1_busy4", 1, 2'b00);
        idle(); q_valid = 2'b01; s0(5, 0, 9, 1);
        cycle("T1_busy5", 1, 2'b00);
        clear_state();

        // T2: RAW split, slot1 stalls until r6 is written back
        q_valid = 2'b11; s0(1, 2, 6, 1); s1(6, 3, 8, 1); rand_data();
        cycle("T2a", 1, 2'b01);
        idle(); q_valid = 2'b01; s0(6, 3, 8, 1);
        cycle("T2b", 1, 2'b00);
        wb_en = 2'b01; wb_rd0 = 5'd6;
        cycle("T2c", 1, 2'b00);
        wb_en = 2'b00;
        cycle("T2d", 1, 2'b01);
        clear_state();

        // T3: two loads split
        q_valid = 2'b11; s0(1, 2, 9, 1); s1(1, 2, 10, 1); q_mem0 = 1; q_mem1 = 1; rand_data();
        cycle("T3a", 1, 2'b01);
        q_valid = 2'b01; s0(1, 2, 10, 1); q_mem0 = 1; q_mem1 = 0; s1(0, 0, 0, 0);
        cycle("T3b", 1, 2'b01);
        clear_state();

        // T4: back-pressure holds outputs and counts stalls
        q_valid = 2'b11; s0(1, 2, 11, 1); s1(1, 2, 12, 1); rand_data();
        cycle("T4a", 1, 2'b11);
        s0(1, 2, 13, 1); s1(1, 2, 14, 1); rand_data();
        out_ready = 0;
        s_before = stall_cnt;
        cycle("T4b", 1, 2'b00);
        cycle("T4c", 1, 2'b00);
        chk("T4_ov_held", 64'(out_valid), 64'h3);
        chk("T4_stall_inc", 64'(stall_cnt), 64'(s_before + 2));
        out_ready = 1;
        cycle("T4d", 1, 2'b11);
        clear_state();

        // T5: writeback and issue of r7 in the same cycle leaves r7 busy
        q_valid = 2'b01; s0(1, 2, 7, 1); wb_en = 2'b01; wb_rd0 = 5'd7; rand_data();
        cycle("T5a", 1, 2'b01);
        idle(); q_valid = 2'b01; s0(7, 0, 9, 1);
        cycle("T5b", 1, 2'b00);
        clear_state();

        // T6: flush clears pipe and scoreboard; r0 writes never mark busy
        q_valid = 2'b11; s0(1, 2, 3, 1); s1(1, 2, 15, 1); rand_data();
        cycle("T6a", 1, 2'b11);
        flush = 1; s0(3, 0, 9, 1); s1(15, 0, 10, 1);
        cycle("T6b", 1, 2'b00);
        chk("T6_ov_clear", 64'(out_valid), 64'd0);
        flush = 0; s0(3, 15, 9, 1); s1(1, 2, 0, 1);
        cycle("T6c", 1, 2'b11);
        idle(); q_valid = 2'b11; s0(0, 0, 0, 1); s1(0, 0, 16, 1);
        cycle("T6d", 1, 2'b11);
        clear_state();

        for (int n = 0; n < 600; n++) begin
            int k;
            k = $urandom_range(0, 3);
            q_valid = (k == 2) ? 2'b11 : 2'(k);
            s0($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            s1($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
            q_mem0 = ($urandom_range(0, 9) < 3); q_mem1 = ($urandom_range(0, 9) < 3);
            q_br0 = ($urandom_range(0, 19) < 3); q_br1 = ($urandom_range(0, 19) < 3);
            q_ser0 = ($urandom_range(0, 19) == 0); q_ser1 = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en = 2'($urandom_range(0, 3));
            wb_rd0 = 5'($urandom_range(0, 7)); wb_rd1 = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 149) == 0);
            rand_data();
            cycle("rand", 0, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
